chaotic_session_ctrl: RTL and testbench
=======================================

CHAOTIC_SESSION_CTRL -- requirements
Module: chaotic_session_ctrl

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 8, plaintext/ciphertext byte width.
REQ-002 SHALL have parameter KEY_WIDTH, default 4*INPUT_WIDTH+1 (33), engine key width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, ciphertext buffer entries (power of 2).
REQ-004 SHALL have parameter LEN_WIDTH, default 16, session byte-count width.
REQ-005 SHALL have ports:
- clk  in  1  clock; one clock domain, all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- cfg_key  in  KEY_WIDTH  session key; sampled at accepted start.
- cfg_len  in  LEN_WIDTH  plaintext bytes in session; sampled at start.
- cfg_warmup  in  8  discard-iteration cycles after key load; sampled at start.
- cfg_start  in  1  start-session pulse.
- cfg_abort  in  1  abort current session.
- s_valid / s_data / s_ready  in/in/out  1/INPUT_WIDTH/1  plaintext stream handshake.
- m_valid / m_data / m_ready  out/out/in  1/INPUT_WIDTH/1  ciphertext stream handshake.
- eng_key / eng_key_valid  out  KEY_WIDTH/1  engine key load.
- eng_pt / eng_pt_valid  out  INPUT_WIDTH/1  engine plaintext issue.
- eng_ct / eng_ct_valid  in  INPUT_WIDTH/1  engine ciphertext return (not stallable).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at session completion.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, WARMUP, STREAM, DRAIN, FLUSH.
REQ-007 IDLE: cfg_start=1 SHALL latch cfg_key/cfg_len/cfg_warmup and go to LOAD; cfg_start outside IDLE SHALL be ignored.
REQ-008 LOAD: exactly one cycle, eng_key_valid=1, eng_key=latched key; then WARMUP if warmup>0, else STREAM if len>0, else DRAIN.
REQ-009 WARMUP: SHALL hold eng_pt_valid=0 for exactly cfg_warmup cycles, then STREAM (or DRAIN if len=0).
REQ-010 STREAM: s_ready SHALL be 1 only when remaining>0 and fifo_count+inflight < FIFO_DEPTH; a handshake (s_valid&s_ready) SHALL drive eng_pt=s_data, eng_pt_valid=1 combinationally in the same cycle.
REQ-011 Each accepted byte SHALL decrement remaining and increment inflight; each eng_ct_valid SHALL decrement inflight and push eng_ct into the FIFO; simultaneous issue and return SHALL leave inflight unchanged.
REQ-012 STREAM SHALL go to DRAIN in the cycle after remaining reaches 0.
REQ-013 DRAIN: when inflight=0 and FIFO empty, SHALL pulse done for one cycle and return to IDLE.
REQ-014 m_valid SHALL equal FIFO non-empty, m_data = FIFO head; pop on m_valid&m_ready; push and pop in the same cycle on a non-empty FIFO SHALL keep count.
REQ-015 The credit rule SHALL guarantee FIFO never overflows; eng_ct_valid arriving on a full FIFO is a design error (assertion).
REQ-016 cfg_abort in LOAD/WARMUP/STREAM/DRAIN SHALL go to FLUSH next cycle (priority over all other transitions); in IDLE/FLUSH it is ignored.
REQ-017 FLUSH: s_ready=0, m_valid=0, FIFO cleared on entry, returning ciphertext discarded; when inflight=0 SHALL go to IDLE with no done pulse.
REQ-018 eng_ct_valid with inflight=0 SHALL be ignored (no push, no underflow).

Reset
REQ-019 rst_n=0 on a clock edge SHALL force IDLE, inflight=0, remaining=0, FIFO empty, and outputs s_ready=0, m_valid=0, m_data=0, eng_key_valid=0, eng_key=0, eng_pt_valid=0, eng_pt=0, busy=0, done=0, regardless of state (including mid-session).

Structure
REQ-020 State encoding, KEY_WIDTH formula and default widths SHALL live in shared package chaotic_pkg.
REQ-021 The ciphertext buffer SHALL be a separate sub-module chaotic_sync_fifo (same clk/rst_n, count output).

Verification
REQ-022 Start key=33'h1_0203_0405, len=4, warmup=3, m_ready=1: eng_key_valid one cycle after start, first s_ready 4 cycles after LOAD, 4 bytes out in order, done once.
REQ-023 len=0, warmup=0: LOAD then DRAIN, done 2 cycles after start, no s_ready.
REQ-024 len=8, m_ready=0, engine latency 2: s_ready drops after 4 accepts, no overflow; raising m_ready delivers all 8 bytes.
REQ-025 Abort during STREAM with 2 inflight: FLUSH discards both returns, no m_valid, no done, busy falls once inflight=0.
REQ-026 rst_n=0 mid-STREAM, then new start: all outputs at reset values, second session completes normally.
REQ-027 cfg_start while busy: ignored, latched key/len unchanged.

Source files
------------

// File: rtl/chaotic_pkg.sv
// chaotic_pkg: shared state encoding and default widths for the chaotic session controller
package chaotic_pkg;

    localparam int DEF_INPUT_WIDTH = 8;
    localparam int DEF_LEN_WIDTH   = 16;
    localparam int DEF_FIFO_DEPTH  = 4;

    // The engine key is four plaintext-widths plus one control bit
    function automatic int key_width(input int w);
        return 4 * w + 1;
    endfunction

    localparam int DEF_KEY_WIDTH = key_width(DEF_INPUT_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARMUP,
        STREAM,
        DRAIN,
        FLUSH
    } state_t;

endpackage

// File: rtl/chaotic_sync_fifo.sv
// chaotic_sync_fifo: ciphertext buffer with synchronous clear and occupancy count
module chaotic_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; a clear drops every stored entry at once
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: only entries below count are ever presented
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_data;
    end

    // The upstream credit scheme must never let a write land on a full buffer
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !clr));

endmodule

// File: rtl/chaotic_session_ctrl.sv
// chaotic_session_ctrl: session sequencer feeding a chaotic stream-cipher engine with credit-based buffering
module chaotic_session_ctrl
    import chaotic_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int KEY_WIDTH   = key_width(INPUT_WIDTH),
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_WIDTH-1:0]   cfg_key,
    input  logic [LEN_WIDTH-1:0]   cfg_len,
    input  logic [7:0]             cfg_warmup,
    input  logic                   cfg_start,
    input  logic                   cfg_abort,
    input  logic                   s_valid,
    input  logic [INPUT_WIDTH-1:0] s_data,
    output logic                   s_ready,
    output logic                   m_valid,
    output logic [INPUT_WIDTH-1:0] m_data,
    input  logic                   m_ready,
    output logic [KEY_WIDTH-1:0]   eng_key,
    output logic                   eng_key_valid,
    output logic [INPUT_WIDTH-1:0] eng_pt,
    output logic                   eng_pt_valid,
    input  logic [INPUT_WIDTH-1:0] eng_ct,
    input  logic                   eng_ct_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                 state;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [7:0]             warm_q;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          fifo_count;
    logic [INPUT_WIDTH-1:0] fifo_head;
    logic                   hs;
    logic                   ret;
    logic                   push;
    logic                   abort_go;
    logic                   fifo_empty;

    assign fifo_empty   = fifo_count == '0;
    assign abort_go     = cfg_abort && state != IDLE && state != FLUSH;
    assign s_ready      = state == STREAM && remaining != '0
                          && ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH);
    assign hs           = s_valid && s_ready;
    assign ret          = eng_ct_valid && inflight != '0;
    assign push         = ret && state != FLUSH;
    assign eng_pt_valid = hs;
    assign eng_pt       = hs ? s_data : '0;
    assign eng_key      = key_q;
    assign busy         = state != IDLE;
    assign m_valid      = !fifo_empty && state != FLUSH;
    assign m_data       = m_valid ? fifo_head : '0;

    // Session sequencing, in-flight credit accounting and registered key/done pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            key_q         <= '0;
            remaining     <= '0;
            warm_q        <= '0;
            inflight      <= '0;
            eng_key_valid <= 1'b0;
            done          <= 1'b0;
        end else begin
            eng_key_valid <= 1'b0;
            done          <= 1'b0;
            inflight      <= inflight + CW'(hs) - CW'(ret);
            if (hs) remaining <= remaining - 1'b1;
            if (abort_go) begin
                state <= FLUSH;
            end else begin
                case (state)
                    IDLE: if (cfg_start) begin
                        key_q         <= cfg_key;
                        remaining     <= cfg_len;
                        warm_q        <= cfg_warmup;
                        eng_key_valid <= 1'b1;
                        state         <= LOAD;
                    end
                    LOAD: state <= warm_q != '0 ? WARMUP : remaining != '0 ? STREAM : DRAIN;
                    WARMUP: begin
                        warm_q <= warm_q - 1'b1;
                        if (warm_q == 8'd1) state <= remaining != '0 ? STREAM : DRAIN;
                    end
                    STREAM: if (remaining == '0) state <= DRAIN;
                    DRAIN: if (inflight == '0 && fifo_empty) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    FLUSH: if (inflight == '0) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    chaotic_sync_fifo #(
        .WIDTH (INPUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (abort_go),
        .push      (push),
        .push_data (eng_ct),
        .pop       (m_valid && m_ready),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_chaotic_session_ctrl.sv
// tb_chaotic_session_ctrl: directed sessions with a ciphertext scoreboard and an XOR engine stand-in
module tb_chaotic_session_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [32:0] cfg_key = '0;
    logic [15:0] cfg_len = '0;
    logic [7:0]  cfg_warmup = '0;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        m_ready = 1'b0;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [32:0] eng_key;
    logic        eng_key_valid;
    logic [7:0]  eng_pt;
    logic        eng_pt_valid;
    logic [7:0]  eng_ct;
    logic        eng_ct_valid;
    logic        busy;
    logic        done;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          lat = 1;
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_exp;
    logic [8:0]  p1 = '0;
    logic [8:0]  p2 = '0;
    logic [8:0]  p3 = '0;

    chaotic_session_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_key       (cfg_key),
        .cfg_len       (cfg_len),
        .cfg_warmup    (cfg_warmup),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .eng_key       (eng_key),
        .eng_key_valid (eng_key_valid),
        .eng_pt        (eng_pt),
        .eng_pt_valid  (eng_pt_valid),
        .eng_ct        (eng_ct),
        .eng_ct_valid  (eng_ct_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Engine stand-in: ciphertext is plaintext XOR 8'h5A after a selectable 1..3 cycle latency
    always @(posedge clk) begin
        p1 <= {eng_pt_valid, eng_pt ^ 8'h5A};
        p2 <= p1;
        p3 <= p2;
    end
    assign eng_ct_valid = (lat == 1) ? p1[8] : (lat == 2) ? p2[8] : p3[8];
    assign eng_ct       = (lat == 1) ? p1[7:0] : (lat == 2) ? p2[7:0] : p3[7:0];

    // Scoreboard monitor: every ciphertext handshake is checked against the queue head
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got=%0h required=none", m_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (m_data !== mon_exp) begin
                    bad++;
                    $display("FAIL sb_data got=%0h required=%0h", m_data, mon_exp);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start(input logic [32:0] k, input logic [15:0] l, input logic [7:0] w);
        cfg_key = k;
        cfg_len = l;
        cfg_warmup = w;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("load_key_valid", 64'(eng_key_valid), 64'd1);
        chk("load_key", 64'(eng_key), 64'(k));
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] e, input bit track);
        int n = 0;
        s_valid = 1'b1;
        s_data = d;
        #1;
        while (!s_ready && n < 40) begin
            step();
            n++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout data=%0h got s_ready=0 required=1", d);
        end else begin
            chk("eng_pt_valid", 64'(eng_pt_valid), 64'd1);
            chk("eng_pt", 64'(eng_pt), 64'(d));
            if (track) exp_q.push_back(e);
        end
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout got busy=1 required=0");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        logic mv;

        repeat (3) step();
        chk("rst_flags", 64'({s_ready, m_valid, eng_key_valid, eng_pt_valid, busy, done}), 64'd0);
        chk("rst_data", 64'({m_data, eng_pt}), 64'd0);
        chk("rst_key", 64'(eng_key), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic session with warmup: first s_ready four cycles after LOAD
        lat = 1;
        m_ready = 1'b1;
        d0 = done_cnt;
        start(33'h1_0203_0405, 16'd4, 8'd3);
        n = 0;
        while (!s_ready && n < 20) begin
            step();
            n++;
        end
        chk("first_s_ready_delay", 64'(n), 64'd4);
        send(8'h11, 8'h4B, 1'b1);
        send(8'h22, 8'h78, 1'b1);
        send(8'h33, 8'h69, 1'b1);
        send(8'h44, 8'h1E, 1'b1);
        wait_idle(n);
        step();
        chk("basic_done_once", 64'(done_cnt - d0), 64'd1);
        chk("basic_sb_empty", 64'(exp_q.size()), 64'd0);

        // Empty session: LOAD, DRAIN, done two cycles after start
        start(33'h0_0000_00FF, 16'd0, 8'd0);
        step();
        chk("empty_drain", 64'({s_ready, busy, done}), 64'b010);
        step();
        chk("empty_done", 64'({busy, done}), 64'b01);
        step();
        chk("empty_done_pulse", 64'(done), 64'd0);

        // Back-pressure: four credits then stall until the sink drains
        lat = 2;
        m_ready = 1'b0;
        d0 = done_cnt;
        start(33'h0_1234_5678, 16'd8, 8'd0);
        step();
        send(8'h01, 8'h5B, 1'b1);
        send(8'h02, 8'h58, 1'b1);
        send(8'h03, 8'h59, 1'b1);
        send(8'h04, 8'h5E, 1'b1);
        chk("credit_stall", 64'(s_ready), 64'd0);
        repeat (3) step();
        chk("credit_stall_hold", 64'(s_ready), 64'd0);
        chk("credit_m_valid", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        send(8'h05, 8'h5F, 1'b1);
        send(8'h06, 8'h5C, 1'b1);
        send(8'h07, 8'h5D, 1'b1);
        send(8'h08, 8'h52, 1'b1);
        wait_idle(n);
        step();
        chk("credit_done_once", 64'(done_cnt - d0), 64'd1);
        chk("credit_sb_empty", 64'(exp_q.size()), 64'd0);

        // Abort with two bytes in flight: both returns discarded
        lat = 3;
        d0 = done_cnt;
        start(33'h0_CAFE_F00D, 16'd4, 8'd0);
        step();
        send(8'hDE, 8'h00, 1'b0);
        send(8'hAD, 8'h00, 1'b0);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("flush_busy", 64'(busy), 64'd1);
        mv = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            mv = mv | m_valid;
            step();
            n++;
        end
        chk("flush_cycles", 64'(n), 64'd3);
        chk("flush_no_m_valid", 64'(mv), 64'd0);
        step();
        chk("flush_no_done", 64'(done_cnt - d0), 64'd0);

        // Reset mid-stream, late returns ignored, then a clean session
        m_ready = 1'b0;
        start(33'h1_FFFF_0000, 16'd4, 8'd0);
        step();
        send(8'h01, 8'h00, 1'b0);
        send(8'h02, 8'h00, 1'b0);
        rst_n = 1'b0;
        step();
        chk("midrst_flags", 64'({s_ready, m_valid, eng_key_valid, eng_pt_valid, busy, done}), 64'd0);
        chk("midrst_data", 64'({m_data, eng_pt}), 64'd0);
        chk("midrst_key", 64'(eng_key), 64'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("late_ct_ignored", 64'({m_valid, busy}), 64'd0);
        lat = 1;
        m_ready = 1'b1;
        d0 = done_cnt;
        start(33'h0_0BAD_BEEF, 16'd2, 8'd1);
        send(8'hA0, 8'hFA, 1'b1);
        send(8'hB1, 8'hEB, 1'b1);
        wait_idle(n);
        step();
        chk("post_rst_done", 64'(done_cnt - d0), 64'd1);
        chk("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);

        // Start while busy is ignored: key and length stay from the first start
        d0 = done_cnt;
        start(33'h0_AAAA_5555, 16'd2, 8'd5);
        step();
        cfg_key = 33'h1_1111_2222;
        cfg_len = 16'd7;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("busy_start_no_load", 64'(eng_key_valid), 64'd0);
        chk("busy_start_key", 64'(eng_key), 64'h0_AAAA_5555);
        send(8'hC3, 8'h99, 1'b1);
        send(8'h7E, 8'h24, 1'b1);
        chk("busy_start_len", 64'(s_ready), 64'd0);
        wait_idle(n);
        step();
        chk("busy_start_done", 64'(done_cnt - d0), 64'd1);
        chk("busy_start_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
